// File: rtl/fb_rect_filler.sv
// Rectangle-fill engine: accepts a clamped rectangle command and issues one
// framebuffer write per granted cycle, row-major, into the arbiter write port.
module fb_rect_filler #(
   parameter int H_PIXELS = 1024,
   parameter int V_PIXELS = 768,
   parameter int ADDR_W   = 20,
   parameter int COORD_W  = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COORD_W-1:0] cmd_x0,
   input  logic [COORD_W-1:0] cmd_y0,
   input  logic [COORD_W-1:0] cmd_x1,
   input  logic [COORD_W-1:0] cmd_y1,
   input  logic               cmd_color,
   input  logic               fb_grant,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic               fb_din,
   output logic               busy,
   output logic               done
);

   localparam int                 LOG2_H   = $clog2(H_PIXELS);
   localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(H_PIXELS);
   localparam logic [ADDR_W-1:0]  ONE_A    = ADDR_W'(1);
   localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);
   localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_PIXELS - 1);
   localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_PIXELS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DONE
   } state_t;

   state_t              r_state,     w_stateNext;
   logic [COORD_W-1:0]  r_x0,        w_x0Next;
   logic [COORD_W-1:0]  r_x1,        w_x1Next;
   logic [COORD_W-1:0]  r_y1,        w_y1Next;
   logic [COORD_W-1:0]  r_x,         w_xNext;
   logic [COORD_W-1:0]  r_y,         w_yNext;
   logic [ADDR_W-1:0]   r_rowBase,   w_rowBaseNext;
   logic                r_cmdReady,  w_cmdReadyNext;
   logic                r_fbWe,      w_fbWeNext;
   logic [ADDR_W-1:0]   r_fbAddr,    w_fbAddrNext;
   logic                r_fbDin,     w_fbDinNext;
   logic                r_busy,      w_busyNext;
   logic                r_done,      w_doneNext;

   logic [COORD_W-1:0]  w_cx0, w_cy0, w_cx1, w_cy1;
   logic [ADDR_W-1:0]   w_firstRowBase;
   logic                w_accept, w_empty, w_lastX, w_lastY;

   function automatic logic [COORD_W-1:0] clampX(input logic [COORD_W-1:0] v);
      return (32'(v) >= 32'(H_PIXELS)) ? X_MAX : v;
   endfunction

   function automatic logic [COORD_W-1:0] clampY(input logic [COORD_W-1:0] v);
      return (32'(v) >= 32'(V_PIXELS)) ? Y_MAX : v;
   endfunction

   // Emptiness is judged on the clamped corners so off-screen spans collapse sensibly.
   assign w_cx0          = clampX(cmd_x0);
   assign w_cx1          = clampX(cmd_x1);
   assign w_cy0          = clampY(cmd_y0);
   assign w_cy1          = clampY(cmd_y1);
   assign w_empty        = (w_cx0 > w_cx1) || (w_cy0 > w_cy1);
   assign w_accept       = cmd_valid && r_cmdReady;
   assign w_firstRowBase = ADDR_W'(w_cy0) << LOG2_H;
   assign w_lastX        = (r_x == r_x1);
   assign w_lastY        = (r_y == r_y1);

   always_comb begin
      w_stateNext    = r_state;
      w_x0Next       = r_x0;
      w_x1Next       = r_x1;
      w_y1Next       = r_y1;
      w_xNext        = r_x;
      w_yNext        = r_y;
      w_rowBaseNext  = r_rowBase;
      w_cmdReadyNext = r_cmdReady;
      w_fbWeNext     = r_fbWe;
      w_fbAddrNext   = r_fbAddr;
      w_fbDinNext    = r_fbDin;
      w_busyNext     = r_busy;
      w_doneNext     = r_done;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cmdReadyNext = 1'b0;
               w_busyNext     = 1'b1;
               if (w_empty) begin
                  w_stateNext = S_DONE;
                  w_doneNext  = 1'b1;
               end else begin
                  w_stateNext   = S_FILL;
                  w_x0Next      = w_cx0;
                  w_x1Next      = w_cx1;
                  w_y1Next      = w_cy1;
                  w_xNext       = w_cx0;
                  w_yNext       = w_cy0;
                  w_rowBaseNext = w_firstRowBase;
                  w_fbWeNext    = 1'b1;
                  w_fbAddrNext  = w_firstRowBase + ADDR_W'(w_cx0);
                  w_fbDinNext   = cmd_color;
               end
            end
         end

         // Without a grant every register holds, so the pending write stays on the port.
         S_FILL: begin
            if (fb_grant) begin
               if (w_lastX && w_lastY) begin
                  w_stateNext = S_DONE;
                  w_fbWeNext  = 1'b0;
                  w_doneNext  = 1'b1;
               end else if (w_lastX) begin
                  w_xNext       = r_x0;
                  w_yNext       = r_y + ONE_C;
                  w_rowBaseNext = r_rowBase + ROW_STEP;
                  w_fbAddrNext  = r_rowBase + ROW_STEP + ADDR_W'(r_x0);
               end else begin
                  w_xNext      = r_x + ONE_C;
                  w_fbAddrNext = r_rowBase + ADDR_W'(r_x) + ONE_A;
               end
            end
         end

         S_DONE: begin
            w_stateNext    = S_IDLE;
            w_doneNext     = 1'b0;
            w_busyNext     = 1'b0;
            w_cmdReadyNext = 1'b1;
         end

         default: begin
            w_stateNext    = S_IDLE;
            w_fbWeNext     = 1'b0;
            w_doneNext     = 1'b0;
            w_busyNext     = 1'b0;
            w_cmdReadyNext = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_x0       <= '0;
         r_x1       <= '0;
         r_y1       <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_rowBase  <= '0;
         r_cmdReady <= 1'b1;
         r_fbWe     <= 1'b0;
         r_fbAddr   <= '0;
         r_fbDin    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_x0       <= w_x0Next;
         r_x1       <= w_x1Next;
         r_y1       <= w_y1Next;
         r_x        <= w_xNext;
         r_y        <= w_yNext;
         r_rowBase  <= w_rowBaseNext;
         r_cmdReady <= w_cmdReadyNext;
         r_fbWe     <= w_fbWeNext;
         r_fbAddr   <= w_fbAddrNext;
         r_fbDin    <= w_fbDinNext;
         r_busy     <= w_busyNext;
         r_done     <= w_doneNext;
      end
   end

   assign cmd_ready = r_cmdReady;
   assign fb_we     = r_fbWe;
   assign fb_addr   = r_fbAddr;
   assign fb_din    = r_fbDin;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_fb_rect_filler.sv
// Self-checking bench for fb_rect_filler: directed and random rectangles
// compared against a nested-loop pixel model of the framebuffer writes.
module tb_fb_rect_filler;

   localparam int H = 1024;
   localparam int V = 768;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   logic       cmd_color = 1'b0;
   logic       fb_grant = 1'b1;
   logic       fb_we;
   logic [19:0] fb_addr;
   logic       fb_din;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int expAddr[$];
   int gotAddr[$];
   logic gotDin[$];

   fb_rect_filler #(
      .H_PIXELS(H),
      .V_PIXELS(V),
      .ADDR_W(20),
      .COORD_W(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0),
      .cmd_y0(cmd_y0),
      .cmd_x1(cmd_x1),
      .cmd_y1(cmd_y1),
      .cmd_color(cmd_color),
      .fb_grant(fb_grant),
      .fb_we(fb_we),
      .fb_addr(fb_addr),
      .fb_din(fb_din),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: clamp each corner, then enumerate every pixel row by row.
   task automatic buildModel(input int x0, input int y0, input int x1, input int y1);
      int cx0, cy0, cx1, cy1;
      cx0 = (x0 >= H) ? H - 1 : x0;
      cx1 = (x1 >= H) ? H - 1 : x1;
      cy0 = (y0 >= V) ? V - 1 : y0;
      cy1 = (y1 >= V) ? V - 1 : y1;
      expAddr.delete();
      for (int y = cy0; y <= cy1; y++)
         for (int x = cx0; x <= cx1; x++)
            expAddr.push_back(y * H + x);
   endtask

   // Grant modes: 0 = always granted, 1 = toggling, 2 = random.
   task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                                input logic color, input int grantMode, input string tag);
      int   k, stalls, busyCyc, weCyc, doneAt, n, m;
      logic [31:0] prevAddr;
      bit   prevStall, finished;
      buildModel(x0, y0, x1, y1);
      gotAddr.delete();
      gotDin.delete();
      k = 0;
      while (cmd_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput({tag, " ready before cmd"}, {31'b0, cmd_ready}, 32'd1);
      cmd_x0    = 10'(x0);
      cmd_y0    = 10'(y0);
      cmd_x1    = 10'(x1);
      cmd_y1    = 10'(y1);
      cmd_color = color;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_x0    = 10'($urandom);
      cmd_y0    = 10'($urandom);
      cmd_x1    = 10'($urandom);
      cmd_y1    = 10'($urandom);
      cmd_color = 1'($urandom);
      stalls = 0; busyCyc = 0; weCyc = 0; doneAt = 0;
      prevStall = 1'b0; finished = 1'b0; prevAddr = '0;
      for (k = 1; k <= 4000 && !finished; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         case (grantMode)
            0:       fb_grant = 1'b1;
            1:       fb_grant = k[0];
            default: fb_grant = ($urandom_range(0, 2) != 0);
         endcase
         @(negedge clk);
         if (k == 1) checkOutput({tag, " ready low after accept"}, {31'b0, cmd_ready}, 32'd0);
         if (busy) busyCyc++;
         if (fb_we) begin
            weCyc++;
            if (prevStall) checkOutput({tag, " addr held in stall"}, {12'b0, fb_addr}, prevAddr);
            if (fb_grant) begin
               gotAddr.push_back(int'(fb_addr));
               gotDin.push_back(fb_din);
               prevStall = 1'b0;
            end else begin
               stalls++;
               prevStall = 1'b1;
               prevAddr  = {12'b0, fb_addr};
            end
         end
         if (done) begin
            doneAt   = k;
            finished = 1'b1;
         end
      end
      fb_grant = 1'b1;
      if (!finished) checkOutput({tag, " done timeout"}, 32'd0, 32'd1);
      n = expAddr.size();
      checkOutput({tag, " write count"}, gotAddr.size(), n);
      checkOutput({tag, " we cycles"}, weCyc, n + stalls);
      checkOutput({tag, " done latency"}, doneAt, n + stalls + 1);
      checkOutput({tag, " busy cycles"}, busyCyc, n + stalls + 1);
      m = (gotAddr.size() < n) ? gotAddr.size() : n;
      for (int i = 0; i < m; i++) begin
         checkOutput({tag, " addr"}, gotAddr[i], expAddr[i]);
         checkOutput({tag, " din"}, {31'b0, gotDin[i]}, {31'b0, color});
      end
      @(negedge clk);
      checkOutput({tag, " done one cycle"}, {31'b0, done}, 32'd0);
      checkOutput({tag, " ready after done"}, {31'b0, cmd_ready}, 32'd1);
      checkOutput({tag, " busy after done"}, {31'b0, busy}, 32'd0);
      checkOutput({tag, " we after done"}, {31'b0, fb_we}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int x0, y0, x1, y1, w, mode, tmp;
      $display("[TB] start");
      repeat (2) @(negedge clk);
      checkOutput("reset cmd_ready", {31'b0, cmd_ready}, 32'd1);
      checkOutput("reset fb_we", {31'b0, fb_we}, 32'd0);
      checkOutput("reset fb_addr", {12'b0, fb_addr}, 32'd0);
      checkOutput("reset fb_din", {31'b0, fb_din}, 32'd0);
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset done", {31'b0, done}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      applyStimulus(5, 3, 5, 3, 1'b1, 0, "single pixel");
      checkOutput("single pixel addr 3077", (gotAddr.size() > 0) ? gotAddr[0] : -1, 32'd3077);
      applyStimulus(10, 5, 13, 6, 1'b1, 0, "small rect");
      applyStimulus(10, 5, 13, 6, 1'b1, 1, "small rect stalled");
      applyStimulus(20, 0, 19, 0, 1'b1, 0, "empty");
      applyStimulus(1020, 766, 1023, 1000, 1'b1, 0, "clamped");
      checkOutput("clamped last addr", (gotAddr.size() > 0) ? gotAddr[gotAddr.size()-1] : -1, 32'd786431);
      applyStimulus(1023, 767, 1023, 767, 1'b0, 2, "corner pixel");

      for (int i = 0; i < 20; i++) begin
         x0   = $urandom_range(0, 1023);
         w    = $urandom_range(0, 5);
         x1   = (x0 + w > 1023) ? 1023 : x0 + w;
         y0   = $urandom_range(0, 1023);
         y1   = y0 + $urandom_range(0, 3);
         if (y1 > 1023) y1 = 1023;
         if ($urandom_range(0, 7) == 0) begin
            tmp = x0; x0 = x1 + 1; x1 = tmp;
            if (x0 > 1023) begin x0 = 1023; x1 = 0; end
         end
         mode = $urandom_range(0, 2);
         applyStimulus(x0, y0, x1, y1, 1'($urandom), mode, "random");
      end

      // Abort a long fill on its 100th write and make sure nothing leaks out afterwards.
      cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_x1 = 10'd199; cmd_y1 = 10'd0;
      cmd_color = 1'b1;
      cmd_valid = 1'b1;
      fb_grant  = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int k = 1; k < 100; k++) @(posedge clk);
      #2;
      checkOutput("100th write we", {31'b0, fb_we}, 32'd1);
      checkOutput("100th write addr", {12'b0, fb_addr}, 32'd99);
      rst = 1'b0;
      #1;
      checkOutput("abort fb_we", {31'b0, fb_we}, 32'd0);
      checkOutput("abort busy", {31'b0, busy}, 32'd0);
      checkOutput("abort done", {31'b0, done}, 32'd0);
      checkOutput("abort cmd_ready", {31'b0, cmd_ready}, 32'd1);
      checkOutput("abort fb_addr", {12'b0, fb_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("post abort no done", {31'b0, done}, 32'd0);
         checkOutput("post abort no write", {31'b0, fb_we}, 32'd0);
      end
      checkOutput("post abort ready", {31'b0, cmd_ready}, 32'd1);
      applyStimulus(100, 200, 103, 202, 1'b1, 2, "after abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fb_rect_filler.md
# fb_rect_filler

Hardware rectangle-fill engine on the write (CPU-clock) side of the 1-bit 1024×768 framebuffer. It accepts a rectangle command over a valid/ready handshake and issues one framebuffer write per granted cycle, row-major, into the framebuffer's `arb_*` write port. The DVI controller scans the same memory out on the read side. The block replaces software loops that write pixels one at a time.

## Interface
Parameters:
- `H_PIXELS`, 1024: framebuffer width. Must be a power of two.
- `V_PIXELS`, 768: framebuffer height.
- `ADDR_W`, 20: framebuffer address width.
- `COORD_W`, 10: coordinate width.

Ports:
- `clk`, in, 1: CPU clock (50 MHz). Single clock domain.
- `rst`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: a command is presented.
- `cmd_ready`, out, 1: engine can accept a command.
- `cmd_x0`, `cmd_y0`, in, COORD_W each: inclusive top-left corner.
- `cmd_x1`, `cmd_y1`, in, COORD_W each: inclusive bottom-right corner.
- `cmd_color`, in, 1: pixel value to write.
- `fb_grant`, in, 1: the arbiter grants the write port this cycle.
- `fb_we`, out, 1: write request; drives `arb_we` through the arbiter.
- `fb_addr`, out, ADDR_W: write address, y*H_PIXELS + x.
- `fb_din`, out, 1: write data.
- `busy`, out, 1: a command is in progress.
- `done`, out, 1: one-cycle pulse when a command completes.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - FILL: `busy`=1, `fb_we`=1.
  - DONE: `done`=1, `busy`=1.
- IDLE→FILL: on `cmd_valid`&`cmd_ready` with a non-empty rectangle. The engine latches the corners (after clamping) and `cmd_color`.
- IDLE→DONE: on an accepted empty command (x0>x1 or y0>y1, compared after clamping). An empty command performs no writes.
- Clamping: any x ≥ H_PIXELS becomes H_PIXELS-1; any y ≥ V_PIXELS becomes V_PIXELS-1. Clamping is applied to all four coordinates.
- FILL write order: row-major, starting at (x0,y0).
  - x increments to x1, then x resets to x0 and y increments.
  - The write at (x1,y1) is the last one. The engine then moves to DONE.
- A write is committed only on a rising edge where `fb_we`=1 and `fb_grant`=1. The engine advances to the next pixel only on such an edge.
- When `fb_grant`=0, `fb_addr`, `fb_din` and `fb_we` hold their values.
- Address generation is incremental, with no multiplier:
  - row_base is loaded with y0<<log2(H_PIXELS).
  - row_base increases by H_PIXELS on each row advance.
  - fb_addr = row_base + x.
  - All arithmetic is ADDR_W bits. The maximum address is 786431, so no overflow is possible.
- DONE→IDLE: unconditionally after one cycle.
- `cmd_*` inputs are ignored outside IDLE.
- Reset: async assertion aborts any command immediately, with no `done` pulse and no further writes. Reset values:
  - `cmd_ready`=1
  - `fb_we`=0, `fb_addr`=0, `fb_din`=0
  - `busy`=0, `done`=0
  - state=IDLE

## Timing
- All outputs are registered.
- Command accepted at edge E0:
  - `fb_we`=1 with the first address is visible after E0.
  - `cmd_ready` drops after E0.
- With `fb_grant` held at 1, a w×h rectangle gives exactly w*h consecutive cycles with `fb_we`=1.
- `done`=1 for the single cycle after the last committed write. `cmd_ready`=1 the cycle after that. Command-to-command turnaround is w*h+2 cycles.
- An empty command gives `done` in the cycle after E0 and `cmd_ready` again one cycle later.
- Each deasserted cycle of `fb_grant` stretches FILL by exactly one cycle. Write order and count are unchanged.

## Test plan
- Single pixel: cmd (5,3)-(5,3), color 1, grant=1 → exactly one write, addr 3077, din 1. `done` 2 cycles after accept.
- Small rectangle: cmd (10,5)-(13,6), color 1 → 8 writes in order 5130..5133, then 6154..6157. `busy` high for 9 cycles.
- Grant stall: same rectangle with `fb_grant` toggled every cycle → same 8 addresses committed in order. Address is held during each stall. `done` arrives 8 cycles later than the unstalled case.
- Empty and clamped commands:
  - (20,0)-(19,0) → zero writes, `done` only.
  - (1020,766)-(1023,1000) → 8 writes. The last address is 786431.
- Full screen: cmd (0,0)-(1023,767), color 0, then the 64-row bar pattern written through the engine. The framebuffer contents seen by the DVI controller match the bars. The Chrontel model reports no timing errors over 2 frames.
- Reset mid-fill: assert `rst` low during the 100th write → `fb_we` drops asynchronously and no `done` pulse. After release, `cmd_ready`=1 and a new command executes normally.
